// File: rtl/uart_tx_fifo_sched_if.sv
// FIFO-read and transmitter-launch signal bundle for the TX drain scheduler.
// master = scheduler side, slave = FIFO/transmitter side.
interface uart_tx_fifo_sched_if #(
  parameter int DATA_W = 8,
  parameter int STAT_W = 4
);
  logic [STAT_W-1:0] Fifo_Status;
  logic [DATA_W-1:0] Fifo_Data;
  logic              Fifo_Read;
  logic              Tx_Busy;
  logic              Tx_Start;
  logic [DATA_W-1:0] Tx_Data;

  modport master (
    input  Fifo_Status,
    input  Fifo_Data,
    input  Tx_Busy,
    output Fifo_Read,
    output Tx_Start,
    output Tx_Data
  );

  modport slave (
    output Fifo_Status,
    output Fifo_Data,
    output Tx_Busy,
    input  Fifo_Read,
    input  Tx_Start,
    input  Tx_Data
  );
endinterface

// File: rtl/uart_tx_fifo_sched.sv
// TX FIFO drain scheduler: pop, capture after read latency, launch, await busy.
// Optional clear-to-send gating via the TX_FLOW_CTRL_EN macro (adds Cts_n).
module uart_tx_fifo_sched #(
  parameter int DATA_W       = 8,
  parameter int STAT_W       = 4,
  parameter int READ_LAT     = 1,
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Enable,
`ifdef TX_FLOW_CTRL_EN
  input  logic        Cts_n,
`endif
  uart_tx_fifo_sched_if.master bus,
  output logic        Idle,
  output logic [15:0] Byte_Count,
  output logic        Tx_Error
);

  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_LAUNCH,
    S_ARM,
    S_SEND
  } state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              cts_ok;
  logic              go;

`ifdef TX_FLOW_CTRL_EN
  assign cts_ok = ~Cts_n;
`else
  assign cts_ok = 1'b1;
`endif

  // Busy already high means someone else owns the transmitter.
  assign go = Enable & cts_ok & ~bus.Tx_Busy
            & (bus.Fifo_Status != '0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state         <= S_IDLE;
      bus.Fifo_Read <= 1'b0;
      bus.Tx_Start  <= 1'b0;
      bus.Tx_Data   <= '0;
      Idle          <= 1'b1;
      Byte_Count    <= '0;
      Tx_Error      <= 1'b0;
      lat_cnt       <= '0;
      gap_cnt       <= '0;
      tmo_cnt       <= '0;
    end else begin
      bus.Fifo_Read <= 1'b0;
      bus.Tx_Start  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_ONE;
            Idle    <= (gap_cnt == GAP_ONE);
          end else if (go) begin
            state         <= S_POP;
            bus.Fifo_Read <= 1'b1;
            Idle          <= 1'b0;
          end else begin
            Idle <= 1'b1;
          end
        end
        S_POP: begin
          state   <= S_WAIT;
          lat_cnt <= '0;
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state        <= S_LAUNCH;
            bus.Tx_Data  <= bus.Fifo_Data;
            bus.Tx_Start <= 1'b1;
            Byte_Count   <= Byte_Count + 16'd1;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_LAUNCH: begin
          // tmo_cnt tracks cycles elapsed since the Tx_Start cycle
          state   <= S_ARM;
          tmo_cnt <= TMO_ONE;
        end
        S_ARM: begin
          if (bus.Tx_Busy) begin
            state <= S_SEND;
          end else if (tmo_cnt == TMO_LAST) begin
            state    <= S_IDLE;
            Tx_Error <= 1'b1;
            Idle     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_SEND: begin
          if (!bus.Tx_Busy) begin
            state   <= S_IDLE;
            gap_cnt <= GAP_LOAD;
            Idle    <= (GAP_CYCLES == 0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_sched.sv
// Bench for uart_tx_fifo_sched: FIFO and transmitter models plus a byte scoreboard.
// Define TX_FLOW_CTRL_EN to also exercise clear-to-send gating.
module tb_uart_tx_fifo_sched;

  localparam int GAP    = 4;
  localparam int BUSY_N = 10;
  localparam int TMO    = 16;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Enable;
  logic        Idle;
  logic        Tx_Error;
  logic [15:0] Byte_Count;
`ifdef TX_FLOW_CTRL_EN
  logic        Cts_n;
`endif

  uart_tx_fifo_sched_if #(.DATA_W(8), .STAT_W(4)) bus ();

  uart_tx_fifo_sched #(
    .DATA_W(8), .STAT_W(4), .READ_LAT(1),
    .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Enable(Enable),
`ifdef TX_FLOW_CTRL_EN
    .Cts_n(Cts_n),
`endif
    .bus(bus),
    .Idle(Idle),
    .Byte_Count(Byte_Count),
    .Tx_Error(Tx_Error)
  );

  always #5 Clk = ~Clk;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int pops = 0;
  int busy_pop_err = 0;
  int underflow_err = 0;
  int lat_err = 0;
  int gap_err = 0;
  int last_pop = -100;
  int fall_cyc = -100;
  int last_launch = 0;
  int err_cyc = 0;
  int busy_len = BUSY_N;
  int busy_left = 0;
  bit pend_rd = 0;
  bit pend_st = 0;
  bit prev_busy = 0;
  bit prev_err = 0;
  bit tx_mode = 1;

  // Observe one full cycle of DUT outputs mid-cycle
  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      if (bus.Fifo_Read === 1'b1) begin
        pops++;
        if (bus.Tx_Busy) busy_pop_err++;
        if (fq.size() == 0) underflow_err++;
        if (cyc - fall_cyc < GAP + 1) gap_err++;
        last_pop = cyc;
        pend_rd = 1;
      end
      if (bus.Tx_Start === 1'b1) begin
        got_q.push_back(bus.Tx_Data);
        if (cyc - last_pop != 2) lat_err++;
        last_launch = cyc;
        pend_st = 1;
      end
      if (prev_busy && !bus.Tx_Busy) fall_cyc = cyc;
      if (Tx_Error === 1'b1 && !prev_err) err_cyc = cyc;
    end
    prev_busy = bus.Tx_Busy;
    prev_err = (Tx_Error === 1'b1);
  end

  // FIFO with 1-cycle read latency and a transmitter that stays busy busy_len cycles
  always @(posedge Clk) begin
    cyc++;
    #1;
    if (pend_rd) begin
      pend_rd = 0;
      if (fq.size() > 0) bus.Fifo_Data = fq.pop_front();
    end
    bus.Fifo_Status = 4'(fq.size());
    if (pend_st) begin
      pend_st = 0;
      if (tx_mode) begin
        bus.Tx_Busy = 1'b1;
        busy_left = busy_len;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) bus.Tx_Busy = 1'b0;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_launch(int n, int lim);
    for (int i = 0; i < lim && got_q.size() < n; i++) @(negedge Clk);
  endtask

  task automatic wait_idle(int lim);
    for (int i = 0; i < lim && !(Idle === 1'b1 && fq.size() == 0); i++)
      @(negedge Clk);
  endtask

  task automatic cmp_stream(string tag);
    int bad;
    bad = 0;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk({tag, "_data"}, bad, 0);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_rd"}, bus.Fifo_Read, 0);
    chk({tag, "_st"}, bus.Tx_Start, 0);
    chk({tag, "_txd"}, bus.Tx_Data, 0);
    chk({tag, "_idle"}, Idle, 1);
    chk({tag, "_cnt"}, Byte_Count, 0);
    chk({tag, "_err"}, Tx_Error, 0);
  endtask

  initial begin
    int p0;
    int l5;
    logic [7:0] last;
    Reset = 1'b0;
    Enable = 1'b0;
`ifdef TX_FLOW_CTRL_EN
    Cts_n = 1'b0;
`endif
    bus.Fifo_Status = '0;
    bus.Fifo_Data = '0;
    bus.Tx_Busy = 1'b0;
    repeat (3) @(negedge Clk);
    chk_reset("rst");
    Reset = 1'b1;

    // single byte, minimum cadence
    Enable = 1'b1;
    push(8'h5A);
    wait_launch(1, 20);
    cmp_stream("t1");
    chk("t1_lat", lat_err, 0);
    chk("t1_pops", pops, 1);
    chk("t1_cnt", Byte_Count, 1);
    wait_idle(60);

    // three queued bytes with 10-cycle busy
    push(8'hA5);
    push(8'hDB);
    push(8'hF0);
    wait_launch(4, 200);
    wait_idle(100);
    cmp_stream("t2");
    chk("t2_pops", pops, 4);
    chk("t2_busy_pop", busy_pop_err, 0);
    chk("t2_cnt", Byte_Count, 4);
    chk("t2_gap", gap_err, 0);

    // empty FIFO
    p0 = pops;
    repeat (50) @(negedge Clk);
    chk("t3_pops", pops, p0);
    chk("t3_idle", Idle, 1);
    chk("t3_underflow", underflow_err, 0);

    // enable drop mid-byte
    p0 = pops;
    push(8'hB1);
    push(8'hC3);
    push(8'h7E);
    for (int i = 0; i < 20 && !bus.Tx_Busy; i++) @(negedge Clk);
    Enable = 1'b0;
    repeat (40) @(negedge Clk);
    chk("t4_pops", pops, p0 + 1);
    chk("t4_idle", Idle, 1);
    chk("t4_status", bus.Fifo_Status, 2);
    Enable = 1'b1;
    wait_launch(6, 40);
    last = (got_q.size() > 0) ? got_q[got_q.size() - 1] : 8'h00;
    chk("t4_next", last, 8'hC3);
    wait_launch(7, 60);
    wait_idle(100);
    cmp_stream("t4");

    // busy never rises: timeout, then keep draining
    tx_mode = 0;
    push(8'h11);
    push(8'h22);
    wait_launch(8, 20);
    l5 = last_launch;
    wait_launch(9, 100);
    wait_idle(100);
    chk("t5_err", Tx_Error, 1);
    chk("t5_err_lat", err_cyc - l5, TMO);
    chk("t5_cnt", Byte_Count, 9);
    cmp_stream("t5");

    // reset while waiting on FIFO data
    tx_mode = 1;
    p0 = pops;
    push(8'h33);
    for (int i = 0; i < 20 && pops == p0; i++) @(negedge Clk);
    chk("t5_pop", pops, p0 + 1);
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1 chk_reset("t5_rst");
    fq.delete();
    exp_q.delete();
    got_q.delete();
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("t5_after_cnt", got_q.size(), 0);

`ifdef TX_FLOW_CTRL_EN
    // clear-to-send gating
    Cts_n = 1'b1;
    p0 = pops;
    push(8'h44);
    push(8'h55);
    push(8'h66);
    repeat (30) @(negedge Clk);
    chk("t6_blocked", pops, p0);
    Cts_n = 1'b0;
    wait_launch(3, 200);
    wait_idle(100);
    cmp_stream("t6");
    chk("t6_gap", gap_err, 0);
`endif

    // randomized traffic with enable toggling and random busy lengths
    for (int i = 0; i < 40; i++) begin
      if (fq.size() < 12) push(8'($urandom));
      busy_len = $urandom_range(1, 12);
      Enable = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(0, 15)) @(negedge Clk);
    end
    Enable = 1'b1;
    wait_launch(exp_q.size(), 3000);
    wait_idle(200);
    cmp_stream("rnd");
    chk("rnd_cnt", Byte_Count, exp_q.size());
    chk("rnd_busy_pop", busy_pop_err, 0);
    chk("rnd_underflow", underflow_err, 0);
    chk("rnd_lat", lat_err, 0);
    chk("rnd_gap", gap_err, 0);
    chk("rnd_err", Tx_Error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
